// File: rtl/debounce_pkg.sv
// debounce_pkg: shared default thresholds and counter sizing for the debouncer family.
package debounce_pkg;
   localparam int DEF_THRESH = 100;
   localparam int DEF_HOLD_THRESH = 1000;
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one channel with synchroniser, symmetric debounce and press/release/hold pulses.
module debounce_channel #(
   parameter int THRESH = 100,
   parameter int HOLD_THRESH = 1000,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic press,
   output logic rel,
   output logic hold
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);
   localparam logic [CNT_W-1:0] HLAST = CNT_W'(HOLD_THRESH - 1);
   localparam logic [CNT_W-1:0] HMAX = CNT_W'(HOLD_THRESH);
   localparam logic HOLD_EN = HOLD_THRESH != 0;
   logic s0, s1, qual, hold_nx;
   logic [CNT_W-1:0] cnt, hcnt, cnt_nx, hcnt_nx;
   // a qualifying release also suppresses a hold due on the same edge
   always_comb begin
      qual = (s1 != level) && (cnt == LAST);
      cnt_nx = (s1 == level || qual) ? '0 : cnt + 1'b1;
      hcnt_nx = (!HOLD_EN || !level || qual) ? '0 : (hcnt == HMAX ? hcnt : hcnt + 1'b1);
      hold_nx = HOLD_EN && level && !qual && (hcnt == HLAST);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
         cnt <= '0;
         hcnt <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rel <= 1'b0;
         hold <= 1'b0;
      end else begin
         s0 <= din;
         s1 <= s0;
         cnt <= cnt_nx;
         hcnt <= hcnt_nx;
         level <= qual ? s1 : level;
         press <= qual && s1;
         rel <= qual && !s1;
         hold <= hold_nx;
      end
   end
endmodule

// File: rtl/debouncer_multi.sv
// debouncer_multi: bank of independent debounce channels with optional input inversion.
module debouncer_multi
   import debounce_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int THRESH = DEF_THRESH,
   parameter int HOLD_THRESH = DEF_HOLD_THRESH,
   parameter int CNT_W = 16,
   parameter bit ACTIVE_LOW_IN = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] raw,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] rel,
   output logic [CHANNELS-1:0] hold
);
   localparam int MAXC = THRESH > HOLD_THRESH ? THRESH : HOLD_THRESH;
   if (CHANNELS < 1 || THRESH < 1 || HOLD_THRESH < 0 || CNT_W < cnt_width(MAXC)) begin : g_bad
      $error("debouncer_multi: illegal parameter combination");
   end
   logic [CHANNELS-1:0] din;
   assign din = ACTIVE_LOW_IN ? ~raw : raw;
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .THRESH(THRESH),
         .HOLD_THRESH(HOLD_THRESH),
         .CNT_W(CNT_W)
      ) u_ch (
         .clk(clk),
         .rst(rst),
         .din(din[i]),
         .level(level[i]),
         .press(press[i]),
         .rel(rel[i]),
         .hold(hold[i])
      );
   end
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: directed vector bench for the multi-channel debouncer.
module tb_debouncer_multi;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [3:0] raw = 4'h0;
   logic [3:0] raw_n = 4'hF;
   logic [3:0] level, press, rel, hold;
   logic [3:0] level_n, press_n, rel_n, hold_n;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   debouncer_multi #(.CHANNELS(4), .THRESH(4), .HOLD_THRESH(10), .CNT_W(8), .ACTIVE_LOW_IN(1'b0)) dut (
      .clk(clk), .rst(rst), .raw(raw),
      .level(level), .press(press), .rel(rel), .hold(hold)
   );

   debouncer_multi #(.CHANNELS(4), .THRESH(4), .HOLD_THRESH(10), .CNT_W(8), .ACTIVE_LOW_IN(1'b1)) dut_n (
      .clk(clk), .rst(rst), .raw(raw_n),
      .level(level_n), .press(press_n), .rel(rel_n), .hold(hold_n)
   );

   typedef struct {
      int n;
      logic rst;
      logic [3:0] raw;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rls;
      logic [3:0] hld;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got lvl/prs/rel/hold=%h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset with all pressed, then clean press/hold/release on every channel
      tbl.push_back('{3, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{5, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0});
      tbl.push_back('{9, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF});
      tbl.push_back('{4, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{5, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0});
      tbl.push_back('{3, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});
      // ch1 bounces then presses with release on the hold edge; ch2 short press
      tbl.push_back('{3, 1'b1, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h6, 4'h4, 4'h4, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h6, 4'h4, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{3, 1'b1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0});
      tbl.push_back('{3, 1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0});
      tbl.push_back('{4, 1'b1, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{5, 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0});
      tbl.push_back('{1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0});
      tbl.push_back('{4, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0});

      foreach (tbl[r]) begin
         for (int k = 0; k < tbl[r].n; k++) begin
            rst = tbl[r].rst;
            raw = tbl[r].raw;
            tick;
            chk($sformatf("row%0d.%0d", r, k), {level, press, rel, hold},
                {tbl[r].lvl, tbl[r].prs, tbl[r].rls, tbl[r].hld});
            chk($sformatf("inv_idle%0d.%0d", r, k), {level_n, press_n, rel_n, hold_n}, 16'h0);
         end
      end

      // reset while ch3 is two counts into a press: progress is discarded
      raw = 4'h8;
      repeat (4) tick;
      chk("midrst_pre", {level, press, rel, hold}, 16'h0);
      rst = 1'b0;
      tick;
      chk("midrst_in", {level, press, rel, hold}, 16'h0);
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk($sformatf("midrst_redo%0d", k), {level, press, rel, hold}, 16'h0);
      end
      tick;
      chk("midrst_press", {level, press, rel, hold}, {4'h8, 4'h8, 4'h0, 4'h0});
      raw = 4'h0;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk($sformatf("midrst_held%0d", k), {level, press, rel, hold}, {4'h8, 4'h0, 4'h0, 4'h0});
      end
      tick;
      chk("midrst_release", {level, press, rel, hold}, {4'h0, 4'h0, 4'h8, 4'h0});

      // active-low instance: raw 0 on ch0 means pressed
      raw_n = 4'hE;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk($sformatf("inv_wait%0d", k), {level_n, press_n, rel_n, hold_n}, 16'h0);
      end
      tick;
      chk("inv_press", {level_n, press_n, rel_n, hold_n}, {4'h1, 4'h1, 4'h0, 4'h0});
      chk("inv_other", {level, press, rel, hold}, 16'h0);
      raw_n = 4'hF;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk($sformatf("inv_held%0d", k), {level_n, press_n, rel_n, hold_n}, {4'h1, 4'h0, 4'h0, 4'h0});
      end
      tick;
      chk("inv_release", {level_n, press_n, rel_n, hold_n}, {4'h0, 4'h0, 4'h1, 4'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
